// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard inputs from the pipeline, and
// the stall/flush strobes, halt status and counters returned to it.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       p0_addr_ID;
  logic [3:0]       p1_addr_ID;
  logic             p0_used_ID;
  logic             p1_used_ID;
  logic [3:0]       dst_addr_EX;
  logic             we_rf_EX;
  logic             re_mem_EX;
  logic             redirect_EX;
  logic             hlt_EX;
  logic             stall_pc;
  logic             stall_IF_ID;
  logic             flush_IF_ID;
  logic             flush_ID_EX;
  logic             halted;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] redirect_cnt;

  // Pipeline side: presents hazard information, consumes strobes.
  modport master (
    output p0_addr_ID, p1_addr_ID, p0_used_ID, p1_used_ID,
    output dst_addr_EX, we_rf_EX, re_mem_EX, redirect_EX, hlt_EX,
    input  stall_pc, stall_IF_ID, flush_IF_ID, flush_ID_EX,
    input  halted, bubble_cnt, redirect_cnt
  );

  // Controller side.
  modport slave (
    input  p0_addr_ID, p1_addr_ID, p0_used_ID, p1_used_ID,
    input  dst_addr_EX, we_rf_EX, re_mem_EX, redirect_EX, hlt_EX,
    output stall_pc, stall_IF_ID, flush_IF_ID, flush_ID_EX,
    output halted, bubble_cnt, redirect_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble insertion, wrong-path squash
// on EX redirects, HLT drain sequencing and saturating perf counters.
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int          CNT_W        = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state_q,    state_d;
  logic [DW-1:0]    dcnt_q,     dcnt_d;
  logic             halted_q,   halted_d;
  logic [CNT_W-1:0] bubble_q,   bubble_d;
  logic [CNT_W-1:0] redirect_q, redirect_d;
  logic             lu;
  logic             stall_pc_d, stall_if_id_d, flush_if_id_d, flush_id_ex_d;

  // Load-use hazard: a load in EX targets a non-zero register that ID reads.
  always_comb begin
    lu = hz.re_mem_EX & hz.we_rf_EX & (hz.dst_addr_EX != 4'd0) &
         ((hz.p0_used_ID & (hz.p0_addr_ID == hz.dst_addr_EX)) |
          (hz.p1_used_ID & (hz.p1_addr_ID == hz.dst_addr_EX)));
  end

  // Strobes and next-state: halt > redirect > load-use in RUN; drain/halted freeze.
  always_comb begin
    state_d       = state_q;
    dcnt_d        = dcnt_q;
    halted_d      = halted_q;
    bubble_d      = bubble_q;
    redirect_d    = redirect_q;
    stall_pc_d    = 1'b0;
    stall_if_id_d = 1'b0;
    flush_if_id_d = 1'b0;
    flush_id_ex_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.hlt_EX) begin
          stall_pc_d    = 1'b1;
          flush_if_id_d = 1'b1;
          flush_id_ex_d = 1'b1;
          state_d       = DRAIN;
          dcnt_d        = DW'(DRAIN_CYCLES);
        end else if (hz.redirect_EX) begin
          flush_if_id_d = 1'b1;
          flush_id_ex_d = 1'b1;
          if (redirect_q != '1) redirect_d = redirect_q + 1'b1;
        end else if (lu) begin
          stall_pc_d    = 1'b1;
          stall_if_id_d = 1'b1;
          flush_id_ex_d = 1'b1;
          if (bubble_q != '1) bubble_d = bubble_q + 1'b1;
        end
      end
      DRAIN: begin
        stall_pc_d    = 1'b1;
        flush_if_id_d = 1'b1;
        flush_id_ex_d = 1'b1;
        dcnt_d        = dcnt_q - 1'b1;
        if (dcnt_q == DW'(1)) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end
      end
      HALTED: begin
        stall_pc_d    = 1'b1;
        flush_if_id_d = 1'b1;
        flush_id_ex_d = 1'b1;
      end
      default: state_d = RUN;
    endcase
    // Reset masks every strobe in the same cycle it is asserted.
    if (rst) begin
      stall_pc_d    = 1'b0;
      stall_if_id_d = 1'b0;
      flush_if_id_d = 1'b0;
      flush_id_ex_d = 1'b0;
    end
  end

  // State, drain counter, halted flag and perf counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      dcnt_q     <= '0;
      halted_q   <= 1'b0;
      bubble_q   <= '0;
      redirect_q <= '0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      halted_q   <= halted_d;
      bubble_q   <= bubble_d;
      redirect_q <= redirect_d;
    end
  end

  assign hz.stall_pc     = stall_pc_d;
  assign hz.stall_IF_ID  = stall_if_id_d;
  assign hz.flush_IF_ID  = flush_if_id_d;
  assign hz.flush_ID_EX  = flush_id_ex_d;
  assign hz.halted       = halted_q;
  assign hz.bubble_cnt   = bubble_q;
  assign hz.redirect_cnt = redirect_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default instance (CNT_W=16) and a
// narrow-counter instance (CNT_W=4) driven with identical stimulus.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) if0 ();
  hazard_ctrl_if #(.CNT_W(4))  if1 ();

  hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .hz(if0));
  hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4))  u1 (.clk(clk), .rst(rst), .hz(if1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive both instances with the same hazard inputs.
  task automatic drive(input logic [3:0] p0a, input logic [3:0] p1a,
                       input logic p0u, input logic p1u, input logic [3:0] dst,
                       input logic we, input logic re, input logic red, input logic hlt);
    if0.p0_addr_ID = p0a; if1.p0_addr_ID = p0a;
    if0.p1_addr_ID = p1a; if1.p1_addr_ID = p1a;
    if0.p0_used_ID = p0u; if1.p0_used_ID = p0u;
    if0.p1_used_ID = p1u; if1.p1_used_ID = p1u;
    if0.dst_addr_EX = dst; if1.dst_addr_EX = dst;
    if0.we_rf_EX = we;    if1.we_rf_EX = we;
    if0.re_mem_EX = re;   if1.re_mem_EX = re;
    if0.redirect_EX = red; if1.redirect_EX = red;
    if0.hlt_EX = hlt;     if1.hlt_EX = hlt;
  endtask

  task automatic idle();
    drive(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Load of r3 in EX, ID reads r3 on p1.
  task automatic lu_p1();
    drive(4'd1, 4'd3, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {stall_pc, stall_IF_ID, flush_IF_ID, flush_ID_EX}
  function automatic logic [3:0] strb0();
    return {if0.stall_pc, if0.stall_IF_ID, if0.flush_IF_ID, if0.flush_ID_EX};
  endfunction

  function automatic logic [3:0] strb1();
    return {if1.stall_pc, if1.stall_IF_ID, if1.flush_IF_ID, if1.flush_ID_EX};
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    step(); step();
    // Strobes forced low while reset is high, even with hlt presented.
    drive(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("rst_strobes", strb0(), 4'b0000);
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("rst_halted", if0.halted, 1'b0);
    check("rst_bubble", if0.bubble_cnt, 0);
    check("rst_redirect", if0.redirect_cnt, 0);
    check("idle_strobes", strb0(), 4'b0000);

    // Load-use on p1, then bubble in EX.
    step(); lu_p1();
    @(negedge clk);
    check("lu_strobes", strb0(), 4'b1101);
    step(); idle();
    @(negedge clk);
    check("lu_after_strobes", strb0(), 4'b0000);
    check("lu_bubble_cnt", if0.bubble_cnt, 1);

    // R0 destination never stalls.
    step(); drive(4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("r0_strobes", strb0(), 4'b0000);
    // Address match only on unused operands.
    step(); drive(4'd5, 4'd5, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("unused_strobes", strb0(), 4'b0000);
    // Not a load (we only).
    step(); drive(4'd5, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("noload_strobes", strb0(), 4'b0000);
    // Match on p0.
    step(); drive(4'd5, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_p0_strobes", strb0(), 4'b1101);
    step(); idle();
    @(negedge clk);
    check("lu_p0_bubble_cnt", if0.bubble_cnt, 2);

    // Redirect wins over a simultaneous load-use.
    step(); drive(4'd1, 4'd3, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("redir_strobes", strb0(), 4'b0011);
    step(); idle();
    @(negedge clk);
    check("redir_cnt", if0.redirect_cnt, 1);
    check("redir_bubble_cnt", if0.bubble_cnt, 2);

    // 20 hazard cycles: wide counter 2+20, narrow one saturates.
    for (int i = 0; i < 20; i++) begin
      step(); lu_p1();
      @(negedge clk);
      if (i == 0) check("sat_first_strobes_w4", strb1(), 4'b1101);
    end
    step(); idle();
    @(negedge clk);
    check("sat_bubble_w16", if0.bubble_cnt, 22);
    check("sat_bubble_w4", if1.bubble_cnt, 4'hF);
    check("sat_redirect_w4", if1.redirect_cnt, 1);

    // Halt at T (with lu present, hlt has priority).
    step(); drive(4'd1, 4'd3, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("hlt_T_strobes", strb0(), 4'b1011);
    check("hlt_T_halted", if0.halted, 1'b0);
    step(); drive(4'd1, 4'd3, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("hlt_T1_strobes", strb0(), 4'b1011);
    check("hlt_T1_halted", if0.halted, 1'b0);
    step(); idle();
    @(negedge clk);
    check("hlt_T2_strobes", strb0(), 4'b1011);
    check("hlt_T2_halted", if0.halted, 1'b0);
    check("hlt_T2_redirect", if0.redirect_cnt, 1);
    step(); lu_p1();
    @(negedge clk);
    check("hlt_T3_halted", if0.halted, 1'b1);
    check("hlt_T3_strobes", strb0(), 4'b1011);
    step(); drive(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("hlt_T4_halted", if0.halted, 1'b1);
    check("hlt_T4_strobes", strb0(), 4'b1011);
    check("hlt_bubble_frozen", if0.bubble_cnt, 22);
    check("hlt_redirect_frozen", if0.redirect_cnt, 1);

    // Reset out of HALTED, then halt and reset mid-drain.
    step(); idle(); rst = 1'b1;
    @(negedge clk);
    check("rst_halted_strobes", strb0(), 4'b0000);
    step(); rst = 1'b0;
    @(negedge clk);
    check("rst2_halted", if0.halted, 1'b0);
    step(); drive(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("hlt2_T_strobes", strb0(), 4'b1011);
    step(); idle(); rst = 1'b1;
    @(negedge clk);
    check("rst_drain_strobes", strb0(), 4'b0000);
    step(); rst = 1'b0;
    @(negedge clk);
    check("rst_drain_halted", if0.halted, 1'b0);
    check("rst_drain_bubble", if0.bubble_cnt, 0);
    check("rst_drain_redirect", if0.redirect_cnt, 0);
    check("rst_drain_strobes_run", strb0(), 4'b0000);
    step(); lu_p1();
    @(negedge clk);
    check("post_rst_lu_strobes", strb0(), 4'b1101);
    step(); idle();
    step(); step();
    @(negedge clk);
    check("post_rst_halted", if0.halted, 1'b0);
    check("post_rst_bubble", if0.bubble_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that drives the `stall` and `flush` inputs of the IF/ID and ID/EX pipeline registers, and the PC hold.
- Detects load-use hazards between the instruction in ID and a load in EX, and inserts one bubble.
- Squashes wrong-path instructions when EX resolves a taken branch or jump.
- Sequences the halt drain: freezes fetch, lets older instructions retire, then reports `halted`.
- Keeps saturating performance counters of bubble and redirect cycles.

## Interface
Parameters
- DRAIN_CYCLES, 2, cycles spent in DRAIN after `hlt_EX` is accepted (stages behind EX: MEM, WB); legal range >=1
- CNT_W, 16, width of the performance counters

Ports
- clk  in  1  pipeline clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- p0_addr_ID  in  4  source register 0 of the instruction in ID
- p1_addr_ID  in  4  source register 1 of the instruction in ID
- p0_used_ID  in  1  ID instruction reads p0
- p1_used_ID  in  1  ID instruction reads p1
- dst_addr_EX  in  4  destination register of the instruction in EX
- we_rf_EX  in  1  EX instruction writes the register file
- re_mem_EX  in  1  EX instruction is a load
- redirect_EX  in  1  EX resolved a taken branch or jump this cycle
- hlt_EX  in  1  EX instruction is HLT
- stall_pc  out  1  hold the PC
- stall_IF_ID  out  1  hold the IF/ID register
- flush_IF_ID  out  1  load NOP (16'hB000) into IF/ID
- flush_ID_EX  out  1  load a bubble into ID/EX
- halted  out  1  pipeline drained after HLT (registered)
- bubble_cnt  out  CNT_W  load-use bubble cycles, saturating
- redirect_cnt  out  CNT_W  accepted redirects, saturating

## Operation
States: RUN, DRAIN, HALTED.

Hazard term, evaluated combinationally:
- `lu = re_mem_EX & we_rf_EX & (dst_addr_EX != 0) & ((p0_used_ID & p0_addr_ID == dst_addr_EX) | (p1_used_ID & p1_addr_ID == dst_addr_EX))`
- R0 never causes a hazard.

RUN, priority highest first:
1. `hlt_EX`: `stall_pc=1`, `flush_IF_ID=1`, `flush_ID_EX=1`. Next state DRAIN, drain counter loaded with DRAIN_CYCLES.
2. `redirect_EX`: `flush_IF_ID=1`, `flush_ID_EX=1`, `stall_pc=0` (PC takes the target). `redirect_cnt` increments. Any simultaneous `lu` is ignored, because the ID instruction is wrong-path.
3. `lu`: `stall_pc=1`, `stall_IF_ID=1`, `flush_ID_EX=1`. `bubble_cnt` increments. State does not change, since the load has moved to MEM next cycle and `lu` clears on its own.
4. Otherwise all strobes are 0.

DRAIN:
- `stall_pc`, `flush_IF_ID` and `flush_ID_EX` held at 1.
- `redirect_EX`, `lu` and `hlt_EX` are ignored and no counters change.
- The drain counter decrements each cycle. The cycle it equals 1, next state is HALTED.

HALTED:
- Same strobes as DRAIN, and `halted=1`.
- Only `rst` leaves this state.

Counters:
- Saturate at all-ones and never wrap.
- Drain counter width is $clog2(DRAIN_CYCLES+1).

## Timing
- Strobe outputs are combinational from the current state and the inputs. They are valid in the same cycle the hazard is visible, so the pipeline registers act on them at the next edge.
- `halted`, the counters and the state are registered.
- If `hlt_EX` is accepted in cycle T:
  - DRAIN occupies T+1 through T+DRAIN_CYCLES.
  - `halted` rises at T+DRAIN_CYCLES+1.
- A load-use hazard costs exactly one bubble. A redirect costs two squashed slots.
- Reset (`rst=1` at an edge, including mid-DRAIN or in HALTED):
  - Next state RUN; drain counter, `halted`, `bubble_cnt` and `redirect_cnt` all 0.
  - While `rst=1`, every strobe output is forced to 0.
- `stall_IF_ID` and `flush_IF_ID` are never both 1.

## Test plan
- Load-use: EX holds a load with `dst=3`, `we_rf_EX=1`; ID has `p1_addr=3`, `p1_used=1` -> that cycle `stall_pc`, `stall_IF_ID` and `flush_ID_EX` are 1. Next cycle (EX is now the bubble) all strobes are 0 and `bubble_cnt=1`.
- R0 / unused operand: `dst=0`, or a match only on a source with `used=0` -> no stall, counters unchanged.
- Redirect with simultaneous hazard: `redirect_EX=1` and `lu=1` -> `flush_IF_ID=1`, `flush_ID_EX=1`, `stall_pc=0`, `stall_IF_ID=0`; `redirect_cnt` increments and `bubble_cnt` does not.
- Halt with DRAIN_CYCLES=2: `hlt_EX=1` at T -> strobes held high from T onward and `halted=1` exactly at T+3. A `redirect_EX` pulse at T+1 is ignored.
- Reset mid-drain: `rst=1` at T+1 -> state RUN, `halted=0`, counters 0, and strobes 0 while `rst` is high.
- Saturation with CNT_W=4: 20 hazard cycles -> `bubble_cnt=4'hF`, no wrap.
